// File: rtl/cpu_mem_pkg.sv
// Shared memory-stage definitions: access size encodings, byte-enable
// patterns, store lane record and the store alignment/lane helpers.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_W   = 2'b00,
        SZ_H   = 2'b01,
        SZ_B   = 2'b10,
        SZ_ILL = 2'b11
    } mem_size_e;

    localparam logic [3:0] BE_W  = 4'b1111;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_B0 = 4'b0001;

    // Lane-replicated write data plus byte enables; the word address is
    // carried alongside so that its width can follow the AW parameter.
    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_lane_t;

    // A store is rejected for the illegal size or a misaligned address.
    function automatic logic st_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_W:    bad = (lo != 2'b00);
            SZ_H:    bad = lo[0];
            SZ_B:    bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replicate the right-justified data onto every lane and pick the enables.
    function automatic st_lane_t st_lanes(input logic [1:0] size, input logic [1:0] lo,
                                          input logic [31:0] data);
        st_lane_t l;
        l.wdata = data;
        l.be    = BE_W;
        case (size)
            SZ_B: begin
                l.wdata = {4{data[7:0]}};
                l.be    = BE_B0 << lo;
            end
            SZ_H: begin
                l.wdata = {2{data[15:0]}};
                l.be    = lo[1] ? BE_H1 : BE_H0;
            end
            default: begin
                l.wdata = data;
                l.be    = BE_W;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/st_align_buf_if.sv
// Store-buffer bus: CPU store request, data-memory write port and the
// load-hazard probe. The slave view is the buffer itself.
interface st_align_buf_if #(
    parameter int unsigned AW = 32
);
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_size;
    logic          st_err;
    logic          dm_valid;
    logic          dm_ready;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [3:0]    dm_be;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic          empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, dm_ready, ld_addr,
        output st_ready, st_err, dm_valid, dm_addr, dm_wdata, dm_be, ld_hit, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, dm_ready, ld_addr,
        input  st_ready, st_err, dm_valid, dm_addr, dm_wdata, dm_be, ld_hit, empty
    );
endinterface

// File: rtl/st_fifo.sv
// Generic synchronous FIFO holding an address plus payload per entry, with
// per-entry valid flags and addresses exposed for hazard comparison.
module st_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [AW-1:0]    head_addr,
    output logic [DW-1:0]    head_data,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] ent_valid,
    output logic [AW-1:0]    ent_addr [DEPTH]
);
    localparam int unsigned    PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign ent_addr  = addr_mem;

    // Pointers wrap modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // An entry is valid when its distance from the read pointer is below count.
    always_comb begin
        ent_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
        end
    end

endmodule

// File: rtl/st_align_buf.sv
// Store alignment buffer: checks store alignment, forms lane-replicated
// write data and byte enables, queues stores and issues them in order.
module st_align_buf
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input logic           clk,
    input logic           rst_n,
    st_align_buf_if.slave bus
);
    localparam int unsigned LW = $bits(st_lane_t);

    logic             full;
    logic             fifo_empty;
    logic             accept;
    logic             illegal;
    logic             push;
    logic             pop;
    logic             st_err_q;
    logic             ld_hit_c;
    st_lane_t         in_lane;
    st_lane_t         head_lane;
    logic [LW-1:0]    head_bits;
    logic [AW-1:0]    head_addr;
    logic [DEPTH-1:0] ent_valid;
    logic [AW-1:0]    ent_addr [DEPTH];

    assign accept    = bus.st_valid && !full;
    assign illegal   = st_misaligned(bus.st_size, bus.st_addr[1:0]);
    assign push      = accept && !illegal;
    assign pop       = !fifo_empty && bus.dm_ready;
    assign in_lane   = st_lanes(bus.st_size, bus.st_addr[1:0], bus.st_data);
    assign head_lane = st_lane_t'(head_bits);

    st_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (LW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_addr({bus.st_addr[AW-1:2], 2'b00}),
        .push_data(in_lane),
        .pop      (pop),
        .head_addr(head_addr),
        .head_data(head_bits),
        .full     (full),
        .empty    (fifo_empty),
        .ent_valid(ent_valid),
        .ent_addr (ent_addr)
    );

    // One-cycle error pulse for an accepted store that was rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_err_q <= 1'b0;
        else        st_err_q <= accept && illegal;
    end

    // Load hazard: any valid entry in the same word, including one popping now.
    always_comb begin
        ld_hit_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i][AW-1:2] == bus.ld_addr[AW-1:2])) ld_hit_c = 1'b1;
        end
    end

    // Memory-side outputs read as zero while nothing is pending.
    assign bus.st_ready = !full;
    assign bus.st_err   = st_err_q;
    assign bus.dm_valid = !fifo_empty;
    assign bus.dm_addr  = fifo_empty ? '0 : head_addr;
    assign bus.dm_wdata = fifo_empty ? '0 : head_lane.wdata;
    assign bus.dm_be    = fifo_empty ? '0 : head_lane.be;
    assign bus.ld_hit   = ld_hit_c;
    assign bus.empty    = fifo_empty;

endmodule
